tensor_partial_product_gen: RTL and testbench

Upstream stage of the tensor output adder. It accepts one 2×2 window of signed activations and weights, forms the four element products with a single shared multiplier over four cycles, and presents them as `ele_0..ele_3`, together with the pass-through shift code `ele_k`. Results are held under a valid/ready handshake until the adder stage takes them.

---
 rtl/tensor_pkg.sv | 18 +
 rtl/tensor_partial_product_gen_if.sv | 29 ++
 rtl/tensor_sat_mult.sv | 34 +++
 rtl/tensor_partial_product_gen.sv | 98 +++++++++
 tb/tb_tensor_partial_product_gen.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_pkg.sv
// Shared definitions for the tensor partial-product generator and the adder stage
// that consumes its output.
package tensor_pkg;

  localparam int DATA_W  = 8;
  localparam int ELE_W   = 16;
  localparam int SHIFT_W = 4;

  localparam logic signed [ELE_W-1:0] ELE_MAX = {1'b0, {(ELE_W-1){1'b1}}};
  localparam logic signed [ELE_W-1:0] ELE_MIN = {1'b1, {(ELE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/tensor_partial_product_gen_if.sv
// Window-in / product-set-out handshake bundle. The master drives the window and
// out_ready; the slave (the generator) drives the products and both status flags.
interface tensor_partial_product_gen_if #(
  parameter int DATA_W  = tensor_pkg::DATA_W,
  parameter int ELE_W   = tensor_pkg::ELE_W,
  parameter int SHIFT_W = tensor_pkg::SHIFT_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] act_0, act_1, act_2, act_3;
  logic signed [DATA_W-1:0] wgt_0, wgt_1, wgt_2, wgt_3;
  logic [SHIFT_W-1:0]       shift;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ELE_W-1:0]  ele_0, ele_1, ele_2, ele_3;
  logic [SHIFT_W-1:0]       ele_k;

  modport master (
    output in_valid, act_0, act_1, act_2, act_3, wgt_0, wgt_1, wgt_2, wgt_3,
           shift, out_ready,
    input  in_ready, out_valid, ele_0, ele_1, ele_2, ele_3, ele_k
  );

  modport slave (
    input  in_valid, act_0, act_1, act_2, act_3, wgt_0, wgt_1, wgt_2, wgt_3,
           shift, out_ready,
    output in_ready, out_valid, ele_0, ele_1, ele_2, ele_3, ele_k
  );
endinterface

// File: rtl/tensor_sat_mult.sv
// Combinational signed DATA_W x DATA_W multiply, saturated (or sign-extended)
// to ELE_W bits.
module tensor_sat_mult #(
  parameter int DATA_W = tensor_pkg::DATA_W,
  parameter int ELE_W  = tensor_pkg::ELE_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ELE_W-1:0]  p
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] full;

  assign full = PROD_W'(a) * PROD_W'(b);

  generate
    if (PROD_W > ELE_W) begin : g_clamp
      localparam logic signed [PROD_W-1:0] MAX_P =
        {{(PROD_W-ELE_W+1){1'b0}}, {(ELE_W-1){1'b1}}};
      localparam logic signed [PROD_W-1:0] MIN_P =
        {{(PROD_W-ELE_W+1){1'b1}}, {(ELE_W-1){1'b0}}};

      always_comb begin
        if (full > MAX_P)      p = MAX_P[ELE_W-1:0];
        else if (full < MIN_P) p = MIN_P[ELE_W-1:0];
        else                   p = full[ELE_W-1:0];
      end
    end else begin : g_extend
      // Signed size cast sign-extends the full product into the wider element.
      assign p = ELE_W'(full);
    end
  endgenerate
endmodule

// File: rtl/tensor_partial_product_gen.sv
// Latches one 2x2 activation/weight window and forms the four element products
// with a single shared saturating multiplier, one product per cycle.
module tensor_partial_product_gen #(
  parameter int DATA_W  = tensor_pkg::DATA_W,
  parameter int ELE_W   = tensor_pkg::ELE_W,
  parameter int SHIFT_W = tensor_pkg::SHIFT_W
) (
  input logic                          clk,
  input logic                          rst,
  tensor_partial_product_gen_if.slave  bus
);
  import tensor_pkg::*;

  state_t                   state, state_nxt;
  logic [1:0]               idx;
  logic signed [DATA_W-1:0] act_q [4];
  logic signed [DATA_W-1:0] wgt_q [4];
  logic signed [ELE_W-1:0]  ele_q [4];
  logic [SHIFT_W-1:0]       k_q;
  logic signed [ELE_W-1:0]  prod;
  logic                     accept;
  logic                     xfer;

  assign accept = bus.in_valid && (state == IDLE);
  assign xfer   = bus.out_ready && (state == HOLD);

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_nxt = MUL;
      end
      MUL: begin
        if (idx == 2'd3) state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  tensor_sat_mult #(
    .DATA_W (DATA_W),
    .ELE_W  (ELE_W)
  ) u_mult (
    .a (act_q[idx]),
    .b (wgt_q[idx]),
    .p (prod)
  );

  // NOTE: the small operand/result arrays are plain flops and are all reset, so
  // a reset mid-operation leaves zeroed outputs with no stale partial set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 2'd0;
      k_q <= '0;
      for (int i = 0; i < 4; i++) begin
        act_q[i] <= '0;
        wgt_q[i] <= '0;
        ele_q[i] <= '0;
      end
    end else if (accept) begin
      idx      <= 2'd0;
      k_q      <= bus.shift;
      act_q[0] <= bus.act_0;
      act_q[1] <= bus.act_1;
      act_q[2] <= bus.act_2;
      act_q[3] <= bus.act_3;
      wgt_q[0] <= bus.wgt_0;
      wgt_q[1] <= bus.wgt_1;
      wgt_q[2] <= bus.wgt_2;
      wgt_q[3] <= bus.wgt_3;
    end else if (state == MUL) begin
      ele_q[idx] <= prod;
      idx        <= idx + 2'd1;  // wraps back to 0 as the set completes
    end
  end

  assign bus.ele_0 = ele_q[0];
  assign bus.ele_1 = ele_q[1];
  assign bus.ele_2 = ele_q[2];
  assign bus.ele_3 = ele_q[3];
  assign bus.ele_k = k_q;
endmodule

// File: tb/tb_tensor_partial_product_gen.sv
// Directed bench for tensor_partial_product_gen: default build plus a DATA_W=12
// build for the clamping path.
module tb_tensor_partial_product_gen;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  tensor_partial_product_gen_if #(.DATA_W(8),  .ELE_W(16), .SHIFT_W(4)) bus ();
  tensor_partial_product_gen_if #(.DATA_W(12), .ELE_W(16), .SHIFT_W(4)) bus12 ();

  tensor_partial_product_gen #(.DATA_W(8), .ELE_W(16), .SHIFT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tensor_partial_product_gen #(.DATA_W(12), .ELE_W(16), .SHIFT_W(4)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_win(input int a0, input int a1, input int a2, input int a3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int sh);
    bus.act_0 = 8'(a0); bus.act_1 = 8'(a1); bus.act_2 = 8'(a2); bus.act_3 = 8'(a3);
    bus.wgt_0 = 8'(w0); bus.wgt_1 = 8'(w1); bus.wgt_2 = 8'(w2); bus.wgt_3 = 8'(w3);
    bus.shift = 4'(sh);
  endtask

  // Waits (bounded) for out_valid on the default build; returns negedges waited.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    n_assert++;
    if ({bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_ele: ele=%0d %0d %0d %0d k=%0d, want all 0",
               bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    n_assert++;
    if (bus12.in_ready !== 1'b1 || bus12.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags12: in_ready=%b out_valid=%b, want 1 0", bus12.in_ready, bus12.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    bus.out_ready = 1'b1;
    set_win(2, 3, 5, -4, 3, 6, 5, 6, 5);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    n_assert++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid after %0d cycles past accept, want 4", cyc);
    end
    n_assert++;
    if ({bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd6, 16'sd18, 16'sd25, -16'sd24}
        || bus.ele_k !== 4'd5) begin
      n_fail++;
      $display("FAIL basic_ele: ele=%0d %0d %0d %0d k=%0d, want 6 18 25 -24 k=5",
               bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_xfer: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_extremes;
    int cyc;
    set_win(-128, 127, -128, 0, -128, 127, 127, -7, 0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    n_assert++;
    if (bus.out_valid !== 1'b1 ||
        {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd16384, 16'sd16129, -16'sd16256, 16'sd0}) begin
      n_fail++;
      $display("FAIL extremes_ele: valid=%b ele=%0d %0d %0d %0d, want 16384 16129 -16256 0",
               bus.out_valid, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3);
    end
    @(negedge clk);
  endtask

  task automatic test_clamp12;
    int cyc;
    bus12.act_0 = 12'(-2048); bus12.act_1 = 12'(2047);  bus12.act_2 = 12'(-2048); bus12.act_3 = 12'(100);
    bus12.wgt_0 = 12'(-2048); bus12.wgt_1 = 12'(-2048); bus12.wgt_2 = 12'(1);     bus12.wgt_3 = 12'(3);
    bus12.shift = 4'd6;
    bus12.in_valid = 1'b1;
    @(negedge clk);
    bus12.in_valid = 1'b0;
    cyc = 0;
    while (bus12.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (bus12.out_valid !== 1'b1 ||
        {bus12.ele_0, bus12.ele_1, bus12.ele_2, bus12.ele_3} !== {16'sd32767, -16'sd32768, -16'sd2048, 16'sd300}) begin
      n_fail++;
      $display("FAIL clamp12_ele: valid=%b ele=%0d %0d %0d %0d, want 32767 -32768 -2048 300",
               bus12.out_valid, bus12.ele_0, bus12.ele_1, bus12.ele_2, bus12.ele_3);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    bus.out_ready = 1'b0;
    set_win(10, -10, 1, 0, 10, 10, -1, 5, 9);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    set_win(1, 2, 3, 4, 1, 1, 1, 1, 3);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_assert++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd100, -16'sd100, -16'sd1, 16'sd0} ||
          bus.ele_k !== 4'd9) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b ele=%0d %0d %0d %0d k=%0d, want 1 0 100 -100 -1 0 k=9",
                 i, bus.out_valid, bus.in_ready, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd100, -16'sd100, -16'sd1, 16'sd0}) begin
      n_fail++;
      $display("FAIL bp_idle_keep: in_ready=%b valid=%b ele=%0d %0d %0d %0d, want 1 0 100 -100 -1 0",
               bus.in_ready, bus.out_valid, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_assert++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: in_ready=%b, want 0", bus.in_ready);
    end
    wait_valid(cyc);
    n_assert++;
    if (cyc != 4 || {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd1, 16'sd2, 16'sd3, 16'sd4}
        || bus.ele_k !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_second_ele: cyc=%0d ele=%0d %0d %0d %0d k=%0d, want 4 1 2 3 4 k=3",
               cyc, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    set_win(1, 1, 1, 1, -1, 2, -3, 4, 1);
    bus.in_valid = 1'b1;
    n_assert++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready0: in_ready=%b, want 1", bus.in_ready);
    end
    @(negedge clk);
    set_win(6, 6, 6, 6, 6, -6, 0, 1, 8);
    repeat (4) @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b1 ||
        {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {-16'sd1, 16'sd2, -16'sd3, 16'sd4} ||
        bus.ele_k !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b ele=%0d %0d %0d %0d k=%0d, want 1 -1 2 -3 4 k=1",
               bus.out_valid, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_cycle5: in_ready=%b, want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_assert++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: in_ready=%b valid=%b, want 0 0", bus.in_ready, bus.out_valid);
    end
    repeat (4) @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b1 ||
        {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd36, -16'sd36, 16'sd0, 16'sd6} ||
        bus.ele_k !== 4'd8) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b ele=%0d %0d %0d %0d k=%0d, want 1 36 -36 0 6 k=8",
               bus.out_valid, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    int cyc;
    int seen;
    bus.out_ready = 1'b1;
    set_win(20, 30, 40, 50, 2, 2, 2, 2, 7);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.ele_0 !== 16'sd40 || bus.ele_1 !== 16'sd60) begin
      n_fail++;
      $display("FAIL rmid_partial: ele0=%0d ele1=%0d, want 40 60", bus.ele_0, bus.ele_1);
    end
    rst = 1'b0;
    #1;
    n_assert++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k} !== 68'd0) begin
      n_fail++;
      $display("FAIL rmid_reset: valid=%b in_ready=%b ele=%0d %0d %0d %0d k=%0d, want 0 1 all 0",
               bus.out_valid, bus.in_ready, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_assert++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rmid_no_output: out_valid seen %0d cycles, want 0", seen);
    end
    set_win(-1, -2, -3, -4, 4, 3, 2, 1, 15);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    n_assert++;
    if (cyc != 4 || {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {-16'sd4, -16'sd6, -16'sd6, -16'sd4}
        || bus.ele_k !== 4'd15) begin
      n_fail++;
      $display("FAIL rmid_next: cyc=%0d ele=%0d %0d %0d %0d k=%0d, want 4 -4 -6 -6 -4 k=15",
               cyc, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
  endtask

  task automatic test_changing_inputs;
    int cyc;
    bus.out_ready = 1'b1;
    set_win(7, -8, 9, -10, 11, 12, -13, 14, 2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      set_win(100 + cyc, -90, 55, 1, -7, 33, 99, 127, 12 + cyc);
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (cyc != 4 || {bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3} !== {16'sd77, -16'sd96, -16'sd117, -16'sd140}
        || bus.ele_k !== 4'd2) begin
      n_fail++;
      $display("FAIL change_inputs: cyc=%0d ele=%0d %0d %0d %0d k=%0d, want 4 77 -96 -117 -140 k=2",
               cyc, bus.ele_0, bus.ele_1, bus.ele_2, bus.ele_3, bus.ele_k);
    end
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus12.in_valid = 1'b0;
    bus12.out_ready = 1'b1;
    bus12.act_0 = '0; bus12.act_1 = '0; bus12.act_2 = '0; bus12.act_3 = '0;
    bus12.wgt_0 = '0; bus12.wgt_1 = '0; bus12.wgt_2 = '0; bus12.wgt_3 = '0;
    bus12.shift = '0;

    test_reset();
    test_basic();
    test_extremes();
    test_clamp12();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_changing_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
